id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, as datapath width for register data and extended immediates.
REQ-002 The block SHALL take parameter RADDR_W, default 5, as register-index width.
REQ-003 The block SHALL take parameter CNT_W, default 16, as stall-counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 if_valid  input  1  instruction word valid from fetch.
REQ-007 instruction  input  32  MIPS-format word: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
REQ-008 rs_addr, rt_addr  output  RADDR_W each  combinational register-file read indices.
REQ-009 rs_data, rt_data  input  DATA_W each  register-file read data, same cycle.
REQ-010 fwd_valid, fwd_rd, fwd_data  input  1/RADDR_W/DATA_W  EX/MEM writeback bypass.
REQ-011 ex_ready  input  1  EX stage accepts ID/EX register contents this cycle.
REQ-012 flush  input  1  discard ID/EX contents and current instruction.
REQ-013 id_ready  output  1  instruction accepted this cycle; fetch advances.
REQ-014 ex_valid, ex_opcode, ex_rd, ex_imm, ex_rs_data, ex_rt_data, ex_store_data  output  1/6/RADDR_W/DATA_W x4  registered ID/EX payload.
REQ-015 ex_mem_read, ex_mem_write, ex_reg_write  output  1 each  registered controls.
REQ-016 branch_taken  output  1  one-cycle pulse, beqz taken.
REQ-017 illegal  output  1  one-cycle pulse, unsupported opcode accepted.
REQ-018 stall_cycles  output  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-019 Decode SHALL support R-type (000000), lw (100011), sw (101011), beqz (000100); imm sign-extended to DATA_W.
REQ-020 Register index 0 SHALL read as zero regardless of rs_data/rt_data.
REQ-021 Operand select: fwd_data when fwd_valid and fwd_rd == index and index != 0, else register data.
REQ-022 Controls per opcode: R-type rd_out=rd, reg_write; lw rd_out=rt, mem_read, reg_write; sw mem_write, store_data=rt operand; beqz no writes.
REQ-023 Load-use hazard: ex_valid and ex_mem_read and ex_rd != 0 and ex_rd matches rs (any opcode) or rt (R-type, sw) -> stall.
REQ-024 Branch hazard: beqz with ex_valid, ex_reg_write, ex_rd == rs != 0 -> stall.
REQ-025 Stall: id_ready=0, ID/EX loads bubble (ex_valid=0, all controls 0) when ex_ready=1; stall_cycles increments, saturating at all-ones.
REQ-026 Backpressure: ex_ready=0 -> ID/EX holds, id_ready=0, no branch_taken/illegal pulse.
REQ-027 Accept (if_valid, no stall, ex_ready, no flush): id_ready=1, ID/EX loads decoded payload, ex_valid=1; latency exactly one cycle.
REQ-028 branch_taken asserts combinationally only in accept cycle when selected rs operand == 0.
REQ-029 Illegal opcode accepted: illegal pulses, ID/EX loads bubble.
REQ-030 flush SHALL override stall and backpressure: ID/EX becomes bubble next edge, id_ready=1, no pulses, no counter increment.
REQ-031 if_valid=0 with ex_ready=1 SHALL load bubble.

Reset
REQ-032 reset low SHALL immediately clear ex_valid, all ex_* payload and controls, and stall_cycles to zero.
REQ-033 Deassertion mid-stream SHALL resume with empty ID/EX; no pulse in first cycle unless an accept occurs.

Structure
REQ-034 Opcode constants and default widths SHALL reside in shared package pipe_pkg.
REQ-035 Hazard detection (REQ-023/024) SHALL be sub-module id_hazard_unit, combinational.

Verification
REQ-036 lw r2,4(r1) then add r3,r2,r4 -> one bubble cycle, id_ready=0 once, stall_cycles=1, add in ID/EX next.
REQ-037 beqz r5 with fwd_valid, fwd_rd=5, fwd_data=0, rs_data=7 -> branch_taken=1, ex_imm=sign-extended offset.
REQ-038 sw r6,-8(r1) with rt_data=0xDEADBEEF -> ex_mem_write=1, ex_imm=0xFFFFFFF8, ex_store_data=0xDEADBEEF.
REQ-039 ex_ready low 3 cycles during lw-use stall -> ID/EX held, stall_cycles unchanged until ex_ready=1.
REQ-040 flush during stall, then reset pulse mid-stream -> ex_valid=0 both times, stall_cycles=0 after reset.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode encodings and default datapath widths.
package pipe_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_BEQZ  = 6'b000100,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  function automatic logic is_legal_opcode(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQZ);
  endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Combinational hazard detection for the decode stage: load-use and
// branch-operand dependencies against the instruction currently in ID/EX.
module id_hazard_unit
  import pipe_pkg::*;
#(
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic [5:0]         opcode,
  input  logic [RADDR_W-1:0] rs_idx,
  input  logic [RADDR_W-1:0] rt_idx,
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic               ex_reg_write,
  input  logic [RADDR_W-1:0] ex_rd,
  output logic               stall
);

  logic uses_rt;
  logic load_use;
  logic branch_hazard;

  // rt is only a source operand for R-type and store instructions.
  always_comb begin
    uses_rt       = (opcode == OP_RTYPE) || (opcode == OP_SW);
    load_use      = ex_valid && ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == rs_idx) || (uses_rt && (ex_rd == rt_idx)));
    branch_hazard = (opcode == OP_BEQZ) && ex_valid && ex_reg_write &&
                    (ex_rd != '0) && (ex_rd == rs_idx);
    stall         = load_use || branch_hazard;
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: operand read with EX/MEM bypass, hazard stalls,
// branch resolution for beqz and the registered ID/EX payload.
module id_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_valid,
  input  logic [31:0]        instruction,
  output logic [RADDR_W-1:0] rs_addr,
  output logic [RADDR_W-1:0] rt_addr,
  input  logic [DATA_W-1:0]  rs_data,
  input  logic [DATA_W-1:0]  rt_data,
  input  logic               fwd_valid,
  input  logic [RADDR_W-1:0] fwd_rd,
  input  logic [DATA_W-1:0]  fwd_data,
  input  logic               ex_ready,
  input  logic               flush,
  output logic               id_ready,
  output logic               ex_valid,
  output logic [5:0]         ex_opcode,
  output logic [RADDR_W-1:0] ex_rd,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_reg_write,
  output logic               branch_taken,
  output logic               illegal,
  output logic [CNT_W-1:0]   stall_cycles
);

  logic [5:0]         opcode;
  logic [RADDR_W-1:0] rd_idx;
  logic [DATA_W-1:0]  imm_ext;
  logic [DATA_W-1:0]  rs_op;
  logic [DATA_W-1:0]  rt_op;
  logic               stall;
  logic               legal;
  logic               accept;

  logic               ex_valid_d, ex_valid_q;
  logic [5:0]         ex_opcode_d, ex_opcode_q;
  logic [RADDR_W-1:0] ex_rd_d, ex_rd_q;
  logic [DATA_W-1:0]  ex_imm_d, ex_imm_q;
  logic [DATA_W-1:0]  ex_rs_data_d, ex_rs_data_q;
  logic [DATA_W-1:0]  ex_rt_data_d, ex_rt_data_q;
  logic [DATA_W-1:0]  ex_store_data_d, ex_store_data_q;
  logic               ex_mem_read_d, ex_mem_read_q;
  logic               ex_mem_write_d, ex_mem_write_q;
  logic               ex_reg_write_d, ex_reg_write_q;
  logic [CNT_W-1:0]   stall_cycles_d, stall_cycles_q;

  // Register 0 is hardwired to zero, so it is never bypassed either.
  function automatic logic [DATA_W-1:0] sel_operand(
    input logic [RADDR_W-1:0] idx,
    input logic [DATA_W-1:0]  reg_data,
    input logic               fv,
    input logic [RADDR_W-1:0] frd,
    input logic [DATA_W-1:0]  fdata
  );
    if (idx == '0) return '0;
    else if (fv && (frd == idx)) return fdata;
    else return reg_data;
  endfunction

  assign opcode  = instruction[31:26];
  assign rs_addr = RADDR_W'(instruction[25:21]);
  assign rt_addr = RADDR_W'(instruction[20:16]);
  assign rd_idx  = RADDR_W'(instruction[15:11]);
  assign imm_ext = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
  assign rs_op   = sel_operand(rs_addr, rs_data, fwd_valid, fwd_rd, fwd_data);
  assign rt_op   = sel_operand(rt_addr, rt_data, fwd_valid, fwd_rd, fwd_data);
  assign legal   = is_legal_opcode(opcode);

  id_hazard_unit #(.RADDR_W(RADDR_W)) u_hazard (
    .opcode       (opcode),
    .rs_idx       (rs_addr),
    .rt_idx       (rt_addr),
    .ex_valid     (ex_valid_q),
    .ex_mem_read  (ex_mem_read_q),
    .ex_reg_write (ex_reg_write_q),
    .ex_rd        (ex_rd_q),
    .stall        (stall)
  );

  // Flush wins over everything; otherwise ID/EX holds under backpressure and
  // takes either the decoded payload or a bubble when EX is ready.
  always_comb begin
    accept          = if_valid && !stall && ex_ready && !flush;
    id_ready        = flush || accept;
    branch_taken    = accept && (opcode == OP_BEQZ) && (rs_op == '0);
    illegal         = accept && !legal;

    ex_valid_d      = ex_valid_q;
    ex_opcode_d     = ex_opcode_q;
    ex_rd_d         = ex_rd_q;
    ex_imm_d        = ex_imm_q;
    ex_rs_data_d    = ex_rs_data_q;
    ex_rt_data_d    = ex_rt_data_q;
    ex_store_data_d = ex_store_data_q;
    ex_mem_read_d   = ex_mem_read_q;
    ex_mem_write_d  = ex_mem_write_q;
    ex_reg_write_d  = ex_reg_write_q;
    stall_cycles_d  = stall_cycles_q;

    if (flush || (ex_ready && !(accept && legal))) begin
      ex_valid_d      = 1'b0;
      ex_opcode_d     = '0;
      ex_rd_d         = '0;
      ex_imm_d        = '0;
      ex_rs_data_d    = '0;
      ex_rt_data_d    = '0;
      ex_store_data_d = '0;
      ex_mem_read_d   = 1'b0;
      ex_mem_write_d  = 1'b0;
      ex_reg_write_d  = 1'b0;
    end else if (accept) begin
      ex_valid_d      = 1'b1;
      ex_opcode_d     = opcode;
      ex_rd_d         = '0;
      ex_imm_d        = imm_ext;
      ex_rs_data_d    = rs_op;
      ex_rt_data_d    = rt_op;
      ex_store_data_d = '0;
      ex_mem_read_d   = 1'b0;
      ex_mem_write_d  = 1'b0;
      ex_reg_write_d  = 1'b0;
      case (opcode)
        OP_RTYPE: begin
          ex_rd_d        = rd_idx;
          ex_reg_write_d = 1'b1;
        end
        OP_LW: begin
          ex_rd_d        = rt_addr;
          ex_mem_read_d  = 1'b1;
          ex_reg_write_d = 1'b1;
        end
        OP_SW: begin
          ex_mem_write_d  = 1'b1;
          ex_store_data_d = rt_op;
        end
        default: ;
      endcase
    end

    // Only stall cycles that actually insert a bubble are counted.
    if (if_valid && stall && ex_ready && !flush && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q      <= 1'b0;
      ex_opcode_q     <= '0;
      ex_rd_q         <= '0;
      ex_imm_q        <= '0;
      ex_rs_data_q    <= '0;
      ex_rt_data_q    <= '0;
      ex_store_data_q <= '0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      stall_cycles_q  <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_opcode_q     <= ex_opcode_d;
      ex_rd_q         <= ex_rd_d;
      ex_imm_q        <= ex_imm_d;
      ex_rs_data_q    <= ex_rs_data_d;
      ex_rt_data_q    <= ex_rt_data_d;
      ex_store_data_q <= ex_store_data_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_reg_write_q  <= ex_reg_write_d;
      stall_cycles_q  <= stall_cycles_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_opcode     = ex_opcode_q;
  assign ex_rd         = ex_rd_q;
  assign ex_imm        = ex_imm_q;
  assign ex_rs_data    = ex_rs_data_q;
  assign ex_rt_data    = ex_rt_data_q;
  assign ex_store_data = ex_store_data_q;
  assign ex_mem_read   = ex_mem_read_q;
  assign ex_mem_write  = ex_mem_write_q;
  assign ex_reg_write  = ex_reg_write_q;
  assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed vector table, corner-case sequences and
// randomized traffic compared against a behavioural decode-stage model.
module tb_id_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam bit [5:0] K_R = 6'h00, K_BEQZ = 6'h04, K_LW = 6'h23, K_SW = 6'h2B;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_valid;
  logic [31:0]   instruction;
  logic [AW-1:0] rs_addr, rt_addr;
  logic [DW-1:0] rs_data, rt_data;
  logic          fwd_valid;
  logic [AW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;
  logic          ex_ready, flush, id_ready, ex_valid;
  logic [5:0]    ex_opcode;
  logic [AW-1:0] ex_rd;
  logic [DW-1:0] ex_imm, ex_rs_data, ex_rt_data, ex_store_data;
  logic          ex_mem_read, ex_mem_write, ex_reg_write, branch_taken, illegal;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  id_stage #(.DATA_W(DW), .RADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .instruction(instruction),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .ex_ready(ex_ready), .flush(flush), .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_imm(ex_imm),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .branch_taken(branch_taken), .illegal(illegal), .stall_cycles(stall_cycles)
  );

  typedef struct {
    bit iv; bit [31:0] ins; bit [31:0] rsd; bit [31:0] rtd;
    bit fv; bit [4:0] frd; bit [31:0] fd; bit er; bit fl;
  } stim_t;

  typedef struct {
    stim_t s; bit idr; bit br; bit il; bit v; bit mr; bit mw; bit rw;
    bit [4:0] rd; bit [31:0] imm; bit [31:0] st; int cnt;
  } vec_t;

  typedef struct {
    bit v; bit [5:0] op; bit [4:0] rd; bit [31:0] imm; bit [31:0] rsd;
    bit [31:0] rtd; bit [31:0] st; bit mr; bit mw; bit rw;
  } idex_t;

  int    checks = 0;
  int    errors = 0;
  idex_t m;
  int    m_cnt;
  vec_t  tbl[$];

  function automatic bit [31:0] enc_r(int rs, int rt, int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction

  function automatic bit [31:0] enc_i(bit [5:0] op, int rs, int rt, bit [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic stim_t mk(bit iv, bit [31:0] ins, bit [31:0] rsd, bit [31:0] rtd,
                               bit fv, bit [4:0] frd, bit [31:0] fd, bit er, bit fl);
    stim_t s;
    s.iv = iv; s.ins = ins; s.rsd = rsd; s.rtd = rtd;
    s.fv = fv; s.frd = frd; s.fd = fd; s.er = er; s.fl = fl;
    return s;
  endfunction

  function automatic bit [31:0] pick(bit [4:0] idx, bit [31:0] rdat, stim_t s);
    if (idx == 0) return 32'd0;
    if (s.fv && s.frd == idx) return s.fd;
    return rdat;
  endfunction

  task automatic add_row(stim_t s, bit idr, bit br, bit il, bit v, bit mr, bit mw, bit rw,
                         bit [4:0] rd, bit [31:0] imm, bit [31:0] st, int cnt);
    vec_t r;
    r.s = s; r.idr = idr; r.br = br; r.il = il; r.v = v; r.mr = mr; r.mw = mw;
    r.rw = rw; r.rd = rd; r.imm = imm; r.st = st; r.cnt = cnt;
    tbl.push_back(r);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    if_valid = s.iv; instruction = s.ins; rs_data = s.rsd; rt_data = s.rtd;
    fwd_valid = s.fv; fwd_rd = s.frd; fwd_data = s.fd; ex_ready = s.er; flush = s.fl;
  endtask

  task automatic compare_state(input string tag);
    checkOutput({tag, " ex_valid"}, 32'(ex_valid), 32'(m.v));
    checkOutput({tag, " ex_opcode"}, 32'(ex_opcode), 32'(m.op));
    checkOutput({tag, " ex_rd"}, 32'(ex_rd), 32'(m.rd));
    checkOutput({tag, " ex_imm"}, ex_imm, m.imm);
    checkOutput({tag, " ex_rs_data"}, ex_rs_data, m.rsd);
    checkOutput({tag, " ex_rt_data"}, ex_rt_data, m.rtd);
    checkOutput({tag, " ex_store_data"}, ex_store_data, m.st);
    checkOutput({tag, " ex_mem_read"}, 32'(ex_mem_read), 32'(m.mr));
    checkOutput({tag, " ex_mem_write"}, 32'(ex_mem_write), 32'(m.mw));
    checkOutput({tag, " ex_reg_write"}, 32'(ex_reg_write), 32'(m.rw));
    checkOutput({tag, " stall_cycles"}, 32'(stall_cycles), 32'(m_cnt));
  endtask

  // One clock of traffic: check decode outputs mid-cycle, then the ID/EX state
  // just after the edge, both against the model.
  task automatic step(input stim_t s, input string tag,
                      output bit c_idr, output bit c_br, output bit c_il);
    bit [5:0]  op;
    bit [4:0]  rs, rt, rdf;
    bit [31:0] a, b, imm;
    bit        haz, acc, legal;
    idex_t     nm;
    int        ncnt;
    applyStimulus(s);
    #3;
    op  = s.ins[31:26]; rs = s.ins[25:21]; rt = s.ins[20:16]; rdf = s.ins[15:11];
    imm = s.ins[15] ? 32'(s.ins[15:0]) - 32'h0001_0000 : 32'(s.ins[15:0]);
    a   = pick(rs, s.rsd, s);
    b   = pick(rt, s.rtd, s);
    legal = op inside {K_R, K_LW, K_SW, K_BEQZ};
    haz = s.iv && m.v &&
          ((m.mr && m.rd != 0 && (m.rd == rs || ((op == K_R || op == K_SW) && m.rd == rt))) ||
           (op == K_BEQZ && m.rw && m.rd != 0 && m.rd == rs));
    acc = s.iv && !haz && s.er && !s.fl;
    c_idr = id_ready; c_br = branch_taken; c_il = illegal;
    checkOutput({tag, " rs_addr"}, 32'(rs_addr), 32'(rs));
    checkOutput({tag, " rt_addr"}, 32'(rt_addr), 32'(rt));
    checkOutput({tag, " id_ready"}, 32'(id_ready), 32'(s.fl || acc));
    checkOutput({tag, " branch_taken"}, 32'(branch_taken), 32'(acc && op == K_BEQZ && a == 0));
    checkOutput({tag, " illegal"}, 32'(illegal), 32'(acc && !legal));
    nm = m; ncnt = m_cnt;
    if (s.fl || (s.er && !(acc && legal))) nm = '{default: 0};
    else if (s.er) begin
      nm.v = 1; nm.op = op; nm.imm = imm; nm.rsd = a; nm.rtd = b;
      nm.mr = (op == K_LW); nm.mw = (op == K_SW); nm.rw = (op == K_R || op == K_LW);
      nm.rd = (op == K_R) ? rdf : (op == K_LW) ? rt : 5'd0;
      nm.st = (op == K_SW) ? b : 32'd0;
    end
    if (haz && s.er && !s.fl && m_cnt < CNT_MAX) ncnt = m_cnt + 1;
    @(posedge clk);
    #1;
    m = nm; m_cnt = ncnt;
    compare_state(tag);
  endtask

  // Asynchronous reset between clock edges with an instruction on the input.
  task automatic do_reset(input string tag);
    applyStimulus(mk(1, enc_i(K_LW, 1, 2, 16'd4), 1, 2, 0, 0, 0, 1, 0));
    #2 reset = 1'b0;
    m = '{default: 0}; m_cnt = 0;
    #1;
    checkOutput({tag, " ex_valid"}, 32'(ex_valid), 0);
    checkOutput({tag, " ex_mem_read"}, 32'(ex_mem_read), 0);
    checkOutput({tag, " ex_reg_write"}, 32'(ex_reg_write), 0);
    checkOutput({tag, " ex_rd"}, 32'(ex_rd), 0);
    checkOutput({tag, " ex_imm"}, ex_imm, 0);
    checkOutput({tag, " stall_cycles"}, 32'(stall_cycles), 0);
    #2;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit    c_idr, c_br, c_il;
    stim_t s;
    bit [5:0] rop;
    m = '{default: 0}; m_cnt = 0;
    do_reset("reset");

    // lw r2,4(r1) ; add r3,r2,r4 -> single bubble
    add_row(mk(1, enc_i(K_LW, 1, 2, 16'd4), 32'h100, 0, 0, 0, 0, 1, 0), 1,0,0, 1,1,0,1, 2, 32'd4, 0, 0);
    add_row(mk(1, enc_r(2, 4, 3), 11, 22, 0, 0, 0, 1, 0), 0,0,0, 0,0,0,0, 0, 0, 0, 1);
    add_row(mk(1, enc_r(2, 4, 3), 11, 22, 0, 0, 0, 1, 0), 1,0,0, 1,0,0,1, 3, 32'h1820, 0, 1);
    // sw r6,-8(r1)
    add_row(mk(1, enc_i(K_SW, 1, 6, 16'hFFF8), 32'h100, 32'hDEADBEEF, 0, 0, 0, 1, 0), 1,0,0, 1,0,1,0, 0, 32'hFFFFFFF8, 32'hDEADBEEF, 1);
    // beqz r5 resolved through the bypass
    add_row(mk(1, enc_i(K_BEQZ, 5, 0, 16'h0010), 7, 0, 1, 5, 0, 1, 0), 1,1,0, 1,0,0,0, 0, 32'h10, 0, 1);
    // lw-use stall held by three cycles of backpressure
    add_row(mk(1, enc_i(K_LW, 1, 2, 16'd0), 5, 0, 0, 0, 0, 1, 0), 1,0,0, 1,1,0,1, 2, 0, 0, 1);
    for (int k = 0; k < 3; k++)
      add_row(mk(1, enc_r(2, 4, 3), 1, 1, 0, 0, 0, 0, 0), 0,0,0, 1,1,0,1, 2, 0, 0, 1);
    add_row(mk(1, enc_r(2, 4, 3), 1, 1, 0, 0, 0, 1, 0), 0,0,0, 0,0,0,0, 0, 0, 0, 2);
    add_row(mk(1, enc_r(2, 4, 3), 1, 1, 0, 0, 0, 1, 0), 1,0,0, 1,0,0,1, 3, 32'h1820, 0, 2);
    // illegal opcode, idle fetch
    add_row(mk(1, enc_i(6'h3F, 1, 1, 16'h0), 0, 0, 0, 0, 0, 1, 0), 1,0,1, 0,0,0,0, 0, 0, 0, 2);
    add_row(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 0,0,0, 0,0,0,0, 0, 0, 0, 2);
    // beqz not taken, then branch hazard behind add r5
    add_row(mk(1, enc_i(K_BEQZ, 5, 0, 16'h0010), 7, 0, 0, 0, 0, 1, 0), 1,0,0, 1,0,0,0, 0, 32'h10, 0, 2);
    add_row(mk(1, enc_r(1, 1, 5), 3, 3, 0, 0, 0, 1, 0), 1,0,0, 1,0,0,1, 5, 32'h2820, 0, 2);
    add_row(mk(1, enc_i(K_BEQZ, 5, 0, 16'h0010), 0, 0, 0, 0, 0, 1, 0), 0,0,0, 0,0,0,0, 0, 0, 0, 3);
    add_row(mk(1, enc_i(K_BEQZ, 5, 0, 16'h0010), 0, 0, 0, 0, 0, 1, 0), 1,1,0, 1,0,0,0, 0, 32'h10, 0, 3);
    // r0 reads zero even with a matching bypass; negative offset
    add_row(mk(1, enc_i(K_BEQZ, 0, 0, 16'h0010), 9, 0, 1, 0, 5, 1, 0), 1,1,0, 1,0,0,0, 0, 32'h10, 0, 3);
    add_row(mk(1, enc_i(K_BEQZ, 5, 0, 16'h8000), 3, 0, 0, 0, 0, 1, 0), 1,0,0, 1,0,0,0, 0, 32'hFFFF8000, 0, 3);

    for (int i = 0; i < tbl.size(); i++) begin
      string t;
      t = $sformatf("row%0d", i);
      step(tbl[i].s, t, c_idr, c_br, c_il);
      checkOutput({t, " tbl id_ready"}, 32'(c_idr), 32'(tbl[i].idr));
      checkOutput({t, " tbl branch_taken"}, 32'(c_br), 32'(tbl[i].br));
      checkOutput({t, " tbl illegal"}, 32'(c_il), 32'(tbl[i].il));
      checkOutput({t, " tbl ex_valid"}, 32'(ex_valid), 32'(tbl[i].v));
      checkOutput({t, " tbl ex_mem_read"}, 32'(ex_mem_read), 32'(tbl[i].mr));
      checkOutput({t, " tbl ex_mem_write"}, 32'(ex_mem_write), 32'(tbl[i].mw));
      checkOutput({t, " tbl ex_reg_write"}, 32'(ex_reg_write), 32'(tbl[i].rw));
      checkOutput({t, " tbl ex_rd"}, 32'(ex_rd), 32'(tbl[i].rd));
      checkOutput({t, " tbl ex_imm"}, ex_imm, tbl[i].imm);
      checkOutput({t, " tbl ex_store_data"}, ex_store_data, tbl[i].st);
      checkOutput({t, " tbl stall_cycles"}, 32'(stall_cycles), 32'(tbl[i].cnt));
    end

    // Flush during a load-use stall, with and without backpressure
    step(mk(1, enc_i(K_LW, 1, 2, 16'd0), 1, 0, 0, 0, 0, 1, 0), "fl0", c_idr, c_br, c_il);
    step(mk(1, enc_r(2, 4, 3), 1, 1, 0, 0, 0, 1, 1), "fl1", c_idr, c_br, c_il);
    checkOutput("flush id_ready", 32'(c_idr), 1);
    checkOutput("flush ex_valid", 32'(ex_valid), 0);
    checkOutput("flush stall_cycles", 32'(stall_cycles), 3);
    step(mk(1, enc_i(K_LW, 1, 2, 16'd0), 1, 0, 0, 0, 0, 1, 0), "fl2", c_idr, c_br, c_il);
    step(mk(1, enc_i(K_BEQZ, 2, 0, 16'd4), 0, 0, 0, 0, 0, 0, 1), "fl3", c_idr, c_br, c_il);
    checkOutput("flush bp id_ready", 32'(c_idr), 1);
    checkOutput("flush bp branch_taken", 32'(c_br), 0);
    checkOutput("flush bp ex_valid", 32'(ex_valid), 0);
    checkOutput("flush bp stall_cycles", 32'(stall_cycles), 3);

    // Reset pulse mid-stream, then an idle first cycle
    step(mk(1, enc_i(K_LW, 1, 2, 16'd8), 1, 0, 0, 0, 0, 1, 0), "pre", c_idr, c_br, c_il);
    do_reset("midreset");
    step(mk(0, enc_i(K_BEQZ, 0, 0, 16'd4), 0, 0, 0, 0, 0, 1, 0), "post", c_idr, c_br, c_il);
    checkOutput("post reset branch_taken", 32'(c_br), 0);
    checkOutput("post reset illegal", 32'(c_il), 0);
    checkOutput("post reset ex_valid", 32'(ex_valid), 0);

    // Counter saturation
    for (int k = 0; k < 17; k++) begin
      step(mk(1, enc_i(K_LW, 1, 2, 16'd0), 1, 0, 0, 0, 0, 1, 0), "sat", c_idr, c_br, c_il);
      step(mk(1, enc_r(2, 4, 3), 1, 1, 0, 0, 0, 1, 0), "sat", c_idr, c_br, c_il);
      step(mk(1, enc_r(2, 4, 3), 1, 1, 0, 0, 0, 1, 0), "sat", c_idr, c_br, c_il);
    end
    checkOutput("stall_cycles saturated", 32'(stall_cycles), CNT_MAX);

    do_reset("prerandom");
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 4))
        0: rop = K_R;
        1: rop = K_LW;
        2: rop = K_SW;
        3: rop = K_BEQZ;
        default: rop = ($urandom_range(0, 1) != 0) ? 6'h3F : 6'h08;
      endcase
      if (rop == K_R)
        s.ins = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      else
        s.ins = enc_i(rop, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom()));
      s.iv  = ($urandom_range(0, 9) != 0);
      s.rsd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      s.rtd = $urandom();
      s.fv  = ($urandom_range(0, 2) == 0);
      s.frd = 5'($urandom_range(0, 7));
      s.fd  = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom();
      s.er  = ($urandom_range(0, 3) != 0);
      s.fl  = ($urandom_range(0, 15) == 0);
      step(s, $sformatf("rnd%0d", n), c_idr, c_br, c_il);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
